// File: rtl/coherence_bus_ctrl.sv
// Coherence bus controller: arbitrates two snooping dcaches onto one RAM port,
// serving read misses cache-to-cache on a dirty snoop hit, otherwise from RAM.
module coherence_bus_ctrl #(
    parameter int SNOOP_WAIT = 2,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        dREN,
    input  logic [1:0]        dWEN,
    input  logic [ADDR_W-1:0] daddr0,
    input  logic [ADDR_W-1:0] daddr1,
    input  logic [ADDR_W-1:0] dstore0,
    input  logic [ADDR_W-1:0] dstore1,
    input  logic [1:0]        cctrans,
    input  logic [1:0]        ccwrite,
    output logic [1:0]        dwait,
    output logic [ADDR_W-1:0] dload0,
    output logic [ADDR_W-1:0] dload1,
    output logic [1:0]        ccwait,
    output logic [1:0]        ccinv,
    output logic [ADDR_W-1:0] ccsnoopaddr0,
    output logic [ADDR_W-1:0] ccsnoopaddr1,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [2:0] {IDLE, WRITE, SNOOP, C2C, LOAD} state_t;

    localparam logic [2:0] CNT_LAST = 3'(SNOOP_WAIT - 1);

    state_t      state;
    logic        g;
    logic        prio;
    logic        word;
    logic [2:0]  cnt;

    logic [1:0]        req;
    logic              gnt;
    logic              o;
    logic [1:0]        gb;
    logic [1:0]        ob;
    logic [ADDR_W-1:0] addr_g;
    logic [ADDR_W-1:0] store_g;
    logic [ADDR_W-1:0] store_o;

    assign req     = dREN | dWEN;
    assign gnt     = (&req) ? prio : req[1];
    assign o       = ~g;
    assign gb      = g ? 2'b10 : 2'b01;
    assign ob      = ~gb;
    assign addr_g  = g ? daddr1 : daddr0;
    assign store_g = g ? dstore1 : dstore0;
    assign store_o = g ? dstore0 : dstore1;

    // prio always ends up pointing at the cache that was not just granted
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            g     <= 1'b0;
            prio  <= 1'b0;
            word  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    word <= 1'b0;
                    cnt  <= '0;
                    if (|req) begin
                        g     <= gnt;
                        prio  <= ~gnt;
                        state <= dWEN[gnt] ? WRITE : SNOOP;
                    end
                end
                WRITE: if (ramready) state <= IDLE;
                SNOOP: begin
                    if (!dREN[g])                state <= IDLE;
                    else if (cctrans[o])         state <= C2C;
                    else if (cnt == CNT_LAST)    state <= LOAD;
                    else                         cnt <= cnt + 3'd1;
                end
                C2C, LOAD: begin
                    if (ramready) begin
                        word <= ~word;
                        if (word || !dREN[g]) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dwait        = 2'b11;
        dload0       = '0;
        dload1       = '0;
        ccwait       = 2'b00;
        ccinv        = 2'b00;
        ccsnoopaddr0 = '0;
        ccsnoopaddr1 = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        unique case (state)
            WRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = addr_g;
                ramstore = store_g;
                if (ramready) dwait = ob;
            end
            SNOOP, C2C: begin
                ccwait = ob;
                ccinv  = ccwrite[g] ? ob : 2'b00;
                if (g) ccsnoopaddr0 = addr_g;
                else   ccsnoopaddr1 = addr_g;
                if (state == C2C) begin
                    ramWEN   = 1'b1;
                    ramaddr  = addr_g;
                    ramstore = store_o;
                    if (g) dload1 = store_o;
                    else   dload0 = store_o;
                    if (ramready) dwait = 2'b00;
                end
            end
            LOAD: begin
                ramREN  = 1'b1;
                ramaddr = addr_g;
                if (g) dload1 = ramload;
                else   dload0 = ramload;
                if (ramready) dwait = ob;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Testbench for coherence_bus_ctrl: transaction-level expectations built from
// the bus protocol rules, randomized addresses, data, latencies and snoop replies.
module tb_coherence_bus_ctrl;

    localparam int SW = 2;

    typedef struct packed {
        logic [1:0]  dwait;
        logic [1:0]  ccwait;
        logic [1:0]  ccinv;
        logic        ren;
        logic        wen;
        logic [31:0] raddr;
        logic [31:0] rstore;
        logic [31:0] dl0;
        logic [31:0] dl1;
        logic [31:0] sa0;
        logic [31:0] sa1;
    } out_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  dREN, dWEN, cctrans, ccwrite;
    logic [31:0] daddr0, daddr1, dstore0, dstore1, ramload;
    logic        ramready;
    logic [1:0]  dwait, ccwait, ccinv;
    logic [31:0] dload0, dload1, ccsnoopaddr0, ccsnoopaddr1, ramaddr, ramstore;
    logic        ramREN, ramWEN;

    int vectors = 0;
    int miscompares = 0;
    bit prio_m;
    out_t obs;

    coherence_bus_ctrl #(.SNOOP_WAIT(SW), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN),
        .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
        .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait),
        .dload0(dload0), .dload1(dload1), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    assign obs = {dwait, ccwait, ccinv, ramREN, ramWEN, ramaddr, ramstore,
                  dload0, dload1, ccsnoopaddr0, ccsnoopaddr1};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic out_t idle_out();
        out_t e = '0;
        e.dwait = 2'b11;
        return e;
    endfunction

    function automatic logic [1:0] cbit(input int c);
        return (c == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic out_t with_dl(input out_t e, input int c, input logic [31:0] v);
        out_t r = e;
        if (c == 0) r.dl0 = v; else r.dl1 = v;
        return r;
    endfunction

    function automatic out_t with_sa(input out_t e, input int c, input logic [31:0] v);
        out_t r = e;
        if (c == 0) r.sa0 = v; else r.sa1 = v;
        return r;
    endfunction

    // Grant rule: both requesting -> priority holder, otherwise the lone requester
    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return int'(prio_m);
        return r[1] ? 1 : 0;
    endfunction

    task automatic set_addr(input int c, input logic [31:0] a);
        if (c == 0) daddr0 = a; else daddr1 = a;
    endtask

    task automatic set_store(input int c, input logic [31:0] d);
        if (c == 0) dstore0 = d; else dstore1 = d;
    endtask

    task automatic clear_inputs();
        dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
        daddr0 = 0; daddr1 = 0; dstore0 = 0; dstore1 = 0;
        ramload = 0; ramready = 0;
    endtask

    task automatic run_write(input int c, input logic [31:0] a, input logic [31:0] d,
                             input int lat, input string tag);
        out_t e;
        #3;
        e = idle_out();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL %s idle: got %h want %h", tag, obs, e);
        end
        prio_m = (c == 0);
        for (int i = 0; i <= lat; i++) begin
            tick();
            ramready = (i == lat);
            #3;
            e = idle_out();
            e.wen = 1; e.raddr = a; e.rstore = d;
            if (ramready) e.dwait = ~cbit(c);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL %s wr cyc%0d: got %h want %h", tag, i, obs, e);
            end
        end
        tick();
        ramready = 0;
        dWEN[c] = 0;
    endtask

    task automatic run_miss(input int c, input logic [31:0] a, input logic ccw,
                            input int lat0, input int lat1, input string tag);
        out_t e;
        int o = 1 - c;
        #3;
        e = idle_out();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL %s idle: got %h want %h", tag, obs, e);
        end
        prio_m = (c == 0);
        for (int i = 0; i < SW; i++) begin
            tick();
            #3;
            e = with_sa(idle_out(), o, a);
            e.ccwait = cbit(o);
            e.ccinv = ccw ? cbit(o) : 2'b00;
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL %s snoop cyc%0d: got %h want %h", tag, i, obs, e);
            end
        end
        for (int w = 0; w < 2; w++) begin
            logic [31:0] wa;
            int lat;
            wa = a + 32'(4 * w);
            lat = (w == 0) ? lat0 : lat1;
            for (int i = 0; i <= lat; i++) begin
                tick();
                set_addr(c, wa);
                ramready = (i == lat);
                ramload = $urandom;
                #3;
                e = with_dl(idle_out(), c, ramload);
                e.ren = 1; e.raddr = wa;
                if (ramready) e.dwait = ~cbit(c);
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL %s load w%0d cyc%0d: got %h want %h", tag, w, i, obs, e);
                end
            end
        end
        tick();
        ramready = 0;
        dREN[c] = 0;
        ccwrite[c] = 0;
    endtask

    task automatic run_c2c(input int c, input logic [31:0] a, input logic ccw,
                           input int d, input logic [31:0] w0, input logic [31:0] w1,
                           input int lat0, input int lat1, input string tag);
        out_t e;
        int o = 1 - c;
        #3;
        e = idle_out();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL %s idle: got %h want %h", tag, obs, e);
        end
        prio_m = (c == 0);
        for (int i = 0; i <= d; i++) begin
            tick();
            cctrans[o] = (i == d);
            #3;
            e = with_sa(idle_out(), o, a);
            e.ccwait = cbit(o);
            e.ccinv = ccw ? cbit(o) : 2'b00;
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL %s snoop cyc%0d: got %h want %h", tag, i, obs, e);
            end
        end
        for (int w = 0; w < 2; w++) begin
            logic [31:0] wa, wd;
            int lat;
            wa = a + 32'(4 * w);
            wd = (w == 0) ? w0 : w1;
            lat = (w == 0) ? lat0 : lat1;
            for (int i = 0; i <= lat; i++) begin
                tick();
                cctrans = 0;
                set_addr(c, wa);
                set_store(o, wd);
                ramready = (i == lat);
                #3;
                e = with_dl(with_sa(idle_out(), o, wa), c, wd);
                e.ccwait = cbit(o);
                e.ccinv = ccw ? cbit(o) : 2'b00;
                e.wen = 1; e.raddr = wa; e.rstore = wd;
                if (ramready) e.dwait = 2'b00;
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL %s c2c w%0d cyc%0d: got %h want %h", tag, w, i, obs, e);
                end
            end
        end
        tick();
        ramready = 0;
        dREN[c] = 0;
        ccwrite[c] = 0;
    endtask

    task automatic test_reset();
        out_t e;
        clear_inputs();
        nRST = 0;
        tick();
        tick();
        #3;
        e = idle_out();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs, e);
        end
        tick();
        nRST = 1;
        prio_m = 0;
    endtask

    task automatic test_write();
        dWEN[0] = 1; daddr0 = 32'h100; dstore0 = 32'hDEAD;
        run_write(0, 32'h100, 32'hDEAD, 2, "write0");
        dWEN[1] = 1; daddr1 = 32'h180; dstore1 = 32'hBEEF;
        run_write(1, 32'h180, 32'hBEEF, 0, "write1");
    endtask

    task automatic test_snoop_miss();
        dREN[1] = 1; daddr1 = 32'h200; ccwrite[1] = 0;
        run_miss(1, 32'h200, 1'b0, 1, 2, "miss");
    endtask

    task automatic test_c2c();
        dREN[0] = 1; daddr0 = 32'h300; ccwrite[0] = 1;
        run_c2c(0, 32'h300, 1'b1, 0, 32'hA5A5, 32'h5A5A, 1, 0, "c2c");
    endtask

    task automatic test_round_robin();
        nRST = 0;
        clear_inputs();
        tick();
        nRST = 1;
        prio_m = 0;
        dREN = 2'b11;
        daddr0 = 32'h1000;
        daddr1 = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            int g = pick(dREN | dWEN);
            logic [31:0] a = (g == 0) ? daddr0 : daddr1;
            run_miss(g, a, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2), "rr");
            dREN[g] = 1;
            set_addr(g, a + 32'h40);
        end
        dREN = 0;
        tick();
    endtask

    task automatic test_reset_mid_c2c();
        out_t e;
        dREN[1] = 1; daddr1 = 32'h400; ccwrite[1] = 0;
        tick();
        cctrans[0] = 1;
        tick();
        cctrans[0] = 0;
        dstore0 = 32'h1234;
        #3;
        e = with_dl(with_sa(idle_out(), 0, 32'h400), 1, 32'h1234);
        e.ccwait = 2'b01; e.wen = 1; e.raddr = 32'h400; e.rstore = 32'h1234;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL pre_reset_c2c: got %h want %h", obs, e);
        end
        nRST = 0;
        tick();
        #3;
        e = idle_out();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_mid_c2c: got %h want %h", obs, e);
        end
        tick();
        nRST = 1;
        prio_m = 0;
        clear_inputs();
        dWEN[0] = 1; daddr0 = 32'h500; dstore0 = 32'h77;
        run_write(0, 32'h500, 32'h77, 1, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int c = $urandom_range(0, 1);
            int kind = $urandom_range(0, 2);
            logic [31:0] a = $urandom & 32'hFFFF_FFF0;
            logic [31:0] d = $urandom;
            logic ccw = 1'($urandom_range(0, 1));
            set_addr(c, a);
            if (kind == 0) begin
                dWEN[c] = 1;
                set_store(c, d);
                run_write(c, a, d, $urandom_range(0, 3), "rnd_wr");
            end else if (kind == 1) begin
                dREN[c] = 1;
                ccwrite[c] = ccw;
                run_miss(c, a, ccw, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_miss");
            end else begin
                dREN[c] = 1;
                ccwrite[c] = ccw;
                run_c2c(c, a, ccw, $urandom_range(0, SW - 1), $urandom, $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 3), "rnd_c2c");
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_snoop_miss();
        test_c2c();
        test_round_robin();
        test_reset_mid_c2c();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
